// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the cpu execution sequencer: FSM states and button lanes.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int BTN_RUN   = 0;
    localparam int BTN_STEP  = 1;
    localparam int BTN_SPEED = 2;
    localparam int BTN_DISP  = 3;
    localparam int BTN_CLR   = 4;
    localparam int NUM_BTN   = 5;

    function automatic logic [1:0] disp_next(input logic [1:0] cur);
        return cur + 2'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser plus a run-length counter that only
// accepts a new level after DEB_CYCLES consecutive differing samples.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q, level_q;
    logic [CW-1:0] cnt_q;
    logic          differ, flip;

    assign differ = (sync2_q != level_q);
    assign flip   = differ && (cnt_q == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            if (flip) begin
                level_q <= ~level_q;
                cnt_q   <= '0;
            end else if (differ) begin
                cnt_q   <= cnt_q + CW'(1);
            end else begin
                cnt_q   <= '0;
            end
        end
    end

    // Press fires in the cycle the rising flip is decided, so the FSM acts on
    // the same edge that the debounced level changes.
    assign level = level_q;
    assign press = flip & ~level_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution sequencer: debounced buttons drive a run/pause/step/halt FSM that
// issues one-cycle cpu_en pulses, counts them, and selects the display page.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int DIV_SLOW   = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             butt_0,
    input  logic             butt_1,
    input  logic             butt_2,
    input  logic             butt_3,
    input  logic             butt_4,
    input  logic             halt_in,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             speed_slow,
    output logic [1:0]       disp_sel,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int DIV_W = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;

    logic [NUM_BTN-1:0] btn_raw, press, unused_level;

    assign btn_raw = {butt_4, butt_3, butt_2, butt_1, butt_0};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .din   (btn_raw[i]),
            .level (unused_level[i]),
            .press (press[i])
        );
    end

    state_t             state_q;
    logic               cpu_en_q, speed_slow_q;
    logic [DIV_W-1:0]   div_cnt_q, div_last;
    logic [1:0]         disp_sel_q, disp_sel_d;
    logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
    logic               div_hit, run_stay, en_d;

    assign div_last = speed_slow_q ? DIV_W'(DIV_SLOW - 1) : '0;
    assign div_hit  = (div_cnt_q == div_last);
    assign run_stay = (state_q == ST_RUN) && !halt_in && !press[BTN_RUN];
    assign en_d     = (run_stay && div_hit) || (state_q == ST_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_PAUSE;
            cpu_en_q     <= 1'b0;
            speed_slow_q <= 1'b0;
            div_cnt_q    <= '0;
        end else begin
            cpu_en_q <= en_d;
            unique case (state_q)
                ST_RUN: begin
                    if (halt_in)             state_q <= ST_HALT;
                    else if (press[BTN_RUN]) state_q <= ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (press[BTN_RUN])       state_q <= ST_RUN;
                    else if (press[BTN_STEP]) state_q <= ST_STEP;
                end
                ST_STEP:  state_q <= halt_in ? ST_HALT : ST_PAUSE;
                ST_HALT: begin
                    if (press[BTN_CLR]) state_q <= ST_PAUSE;
                end
            endcase

            if (press[BTN_SPEED]) speed_slow_q <= ~speed_slow_q;

            // A speed change restarts the divider so the new period starts clean.
            if (press[BTN_SPEED] || (state_q == ST_PAUSE && press[BTN_RUN]))
                div_cnt_q <= '0;
            else if (run_stay)
                div_cnt_q <= div_hit ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    always_comb begin
        disp_sel_d = press[BTN_DISP] ? disp_next(disp_sel_q) : disp_sel_q;
        instr_cnt_d = instr_cnt_q;
        if (press[BTN_CLR])
            instr_cnt_d = '0;
        else if (en_d)
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_sel_q  <= 2'd0;
            instr_cnt_q <= '0;
        end else begin
            disp_sel_q  <= disp_sel_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign state      = state_q;
    assign speed_slow = speed_slow_q;
    assign disp_sel   = disp_sel_q;
    assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DEB_CYCLES=4, DIV_SLOW=16, CNT_W=8.
module tb_cpu_run_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       butt = '0;
    logic             halt_in = 1'b0;
    logic             cpu_en;
    logic [1:0]       state;
    logic             speed_slow;
    logic [1:0]       disp_sel;
    logic [CNT_W-1:0] instr_cnt;

    int errors = 0;
    int checks = 0;

    cpu_run_ctrl #(.DEB_CYCLES(4), .DIV_SLOW(16), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .butt_0     (butt[0]),
        .butt_1     (butt[1]),
        .butt_2     (butt[2]),
        .butt_3     (butt[3]),
        .butt_4     (butt[4]),
        .halt_in    (halt_in),
        .cpu_en     (cpu_en),
        .state      (state),
        .speed_slow (speed_slow),
        .disp_sel   (disp_sel),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        butt    = '0;
        halt_in = 1'b0;
        rst     = 1'b1;
        tick(2);
        rst     = 1'b0;
    endtask

    // Hold a button high then low for 'hold' cycles each, counting cpu_en cycles seen.
    task automatic press_btn(input int idx, input int hold, output int en_seen);
        en_seen = 0;
        butt[idx] = 1'b1;
        repeat (hold) begin tick(); en_seen += int'(cpu_en); end
        butt[idx] = 1'b0;
        repeat (hold) begin tick(); en_seen += int'(cpu_en); end
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        checks++;
        if (state !== 2'(ST_PAUSE) || cpu_en !== 1'b0 || instr_cnt !== '0 ||
            speed_slow !== 1'b0 || disp_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: state=%0d en=%0d cnt=%0d slow=%0d disp=%0d expected 0 1? no: 0,0,0,0,0",
                     state, cpu_en, instr_cnt, speed_slow, disp_sel);
        end
        bad = 0;
        repeat (100) begin
            tick();
            if (state !== 2'(ST_PAUSE) || cpu_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || instr_cnt !== '0) begin
            errors++;
            $display("FAIL idle_pause: bad_cycles=%0d cnt=%0d expected 0 and 0", bad, instr_cnt);
        end
    endtask

    task automatic test_held_through_reset();
        int en_seen;
        butt = '0; halt_in = 1'b0;
        rst = 1'b1; butt[0] = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(5);
        checks++;
        if (state !== 2'(ST_PAUSE)) begin
            errors++; $display("FAIL held_early: state=%0d expected %0d", state, ST_PAUSE);
        end
        tick();
        checks++;
        if (state !== 2'(ST_RUN) || cpu_en !== 1'b0) begin
            errors++; $display("FAIL held_run_entry: state=%0d en=%0d expected 1 0", state, cpu_en);
        end
        en_seen = 0;
        repeat (10) begin tick(); en_seen += int'(cpu_en); end
        checks++;
        if (en_seen != 10 || instr_cnt !== 8'd10) begin
            errors++; $display("FAIL fast_run: en_cycles=%0d cnt=%0d expected 10 10", en_seen, instr_cnt);
        end
        butt[0] = 1'b0;
        tick(8);
    endtask

    task automatic test_step();
        int en_seen, rises;
        logic prev;
        do_reset();
        en_seen = 0; rises = 0; prev = 1'b0;
        repeat (3) begin
            for (int ph = 0; ph < 2; ph++) begin
                butt[1] = (ph == 0);
                repeat (8) begin
                    tick();
                    en_seen += int'(cpu_en);
                    if (cpu_en && !prev) rises++;
                    prev = cpu_en;
                end
            end
        end
        checks++;
        if (en_seen != 3 || rises != 3) begin
            errors++; $display("FAIL step_pulses: en_cycles=%0d rises=%0d expected 3 3", en_seen, rises);
        end
        checks++;
        if (instr_cnt !== 8'd3 || state !== 2'(ST_PAUSE)) begin
            errors++; $display("FAIL step_end: cnt=%0d state=%0d expected 3 0", instr_cnt, state);
        end
    endtask

    task automatic test_slow_and_glitch();
        int en_seen, waited, period;
        do_reset();
        press_btn(2, 8, en_seen);
        checks++;
        if (speed_slow !== 1'b1) begin
            errors++; $display("FAIL speed_toggle: slow=%0d expected 1", speed_slow);
        end
        press_btn(0, 8, en_seen);
        waited = 0;
        while (cpu_en !== 1'b1 && waited < 40) begin tick(); waited++; end
        checks++;
        if (waited != 6) begin
            errors++; $display("FAIL slow_first_pulse: waited=%0d expected 6", waited);
        end
        period = 0;
        do begin tick(); period++; end while (cpu_en !== 1'b1 && period < 40);
        checks++;
        if (period != 16) begin
            errors++; $display("FAIL slow_period: period=%0d expected 16", period);
        end
        butt[0] = 1'b1; tick(2); butt[0] = 1'b0; tick(12);
        checks++;
        if (state !== 2'(ST_RUN)) begin
            errors++; $display("FAIL glitch_ignored: state=%0d expected %0d", state, ST_RUN);
        end
        press_btn(2, 8, en_seen);
        tick();
        checks++;
        if (speed_slow !== 1'b0 || cpu_en !== 1'b1) begin
            errors++; $display("FAIL back_to_fast: slow=%0d en=%0d expected 0 1", speed_slow, cpu_en);
        end
    endtask

    task automatic test_halt_clear();
        int en_seen;
        do_reset();
        press_btn(0, 8, en_seen);
        checks++;
        if (instr_cnt !== 8'd10 || state !== 2'(ST_RUN)) begin
            errors++; $display("FAIL run_count: cnt=%0d state=%0d expected 10 1", instr_cnt, state);
        end
        halt_in = 1'b1;
        tick();
        checks++;
        if (state !== 2'(ST_HALT) || cpu_en !== 1'b0 || instr_cnt !== 8'd10) begin
            errors++; $display("FAIL halt_entry: state=%0d en=%0d cnt=%0d expected 3 0 10", state, cpu_en, instr_cnt);
        end
        press_btn(0, 8, en_seen);
        checks++;
        if (state !== 2'(ST_HALT) || en_seen != 0) begin
            errors++; $display("FAIL halt_hold: state=%0d en_cycles=%0d expected 3 0", state, en_seen);
        end
        halt_in = 1'b0;
        press_btn(4, 8, en_seen);
        checks++;
        if (state !== 2'(ST_PAUSE) || instr_cnt !== '0 || en_seen != 0) begin
            errors++; $display("FAIL halt_clear: state=%0d cnt=%0d en_cycles=%0d expected 0 0 0", state, instr_cnt, en_seen);
        end
    endtask

    task automatic test_clear_priority_and_wrap();
        int en_seen;
        do_reset();
        butt[0] = 1'b1; butt[1] = 1'b1;
        tick(8);
        butt[0] = 1'b0; butt[1] = 1'b0;
        tick(8);
        checks++;
        if (state !== 2'(ST_RUN) || instr_cnt !== 8'd10) begin
            errors++; $display("FAIL run_beats_step: state=%0d cnt=%0d expected 1 10", state, instr_cnt);
        end
        butt[4] = 1'b1;
        tick(5);
        tick();
        checks++;
        if (instr_cnt !== 8'd0 || cpu_en !== 1'b1) begin
            errors++; $display("FAIL clear_wins: cnt=%0d en=%0d expected 0 1", instr_cnt, cpu_en);
        end
        tick();
        checks++;
        if (instr_cnt !== 8'd1) begin
            errors++; $display("FAIL after_clear: cnt=%0d expected 1", instr_cnt);
        end
        butt[4] = 1'b0;
        tick(254);
        checks++;
        if (instr_cnt !== 8'd255) begin
            errors++; $display("FAIL pre_wrap: cnt=%0d expected 255", instr_cnt);
        end
        tick();
        checks++;
        if (instr_cnt !== 8'd0 || cpu_en !== 1'b1) begin
            errors++; $display("FAIL wrap: cnt=%0d en=%0d expected 0 1", instr_cnt, cpu_en);
        end
        press_btn(0, 8, en_seen);
    endtask

    task automatic test_disp_and_reset();
        int en_seen;
        logic [1:0] exp_disp [5];
        exp_disp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            press_btn(3, 8, en_seen);
            checks++;
            if (disp_sel !== exp_disp[k]) begin
                errors++; $display("FAIL disp_page%0d: disp=%0d expected %0d", k, disp_sel, exp_disp[k]);
            end
        end
        press_btn(0, 8, en_seen);
        press_btn(2, 8, en_seen);
        rst = 1'b1;
        tick();
        checks++;
        if (state !== 2'(ST_PAUSE) || cpu_en !== 1'b0 || instr_cnt !== '0 ||
            speed_slow !== 1'b0 || disp_sel !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: state=%0d en=%0d cnt=%0d slow=%0d disp=%0d expected all 0",
                     state, cpu_en, instr_cnt, speed_slow, disp_sel);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_drops_step();
        do_reset();
        butt[1] = 1'b1;
        tick(6);
        checks++;
        if (state !== 2'(ST_STEP)) begin
            errors++; $display("FAIL step_entry: state=%0d expected %0d", state, ST_STEP);
        end
        rst = 1'b1;
        tick();
        butt[1] = 1'b0;
        checks++;
        if (cpu_en !== 1'b0 || state !== 2'(ST_PAUSE)) begin
            errors++; $display("FAIL step_dropped: en=%0d state=%0d expected 0 0", cpu_en, state);
        end
        rst = 1'b0;
        tick(10);
        checks++;
        if (instr_cnt !== '0) begin
            errors++; $display("FAIL step_dropped_cnt: cnt=%0d expected 0", instr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_held_through_reset();
        test_step();
        test_slow_and_glitch();
        test_halt_clear();
        test_clear_priority_and_wrap();
        test_disp_and_reset();
        test_reset_drops_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
